// File: rtl/seg7_pkg.sv
// seg7_pkg: shared codes, patterns, scan FSM states and default timing for the
// 4-digit common-anode 7-segment display driver.
package seg7_pkg;

  // Digit codes with bit4 set; anything other than DASH is treated as blank.
  localparam logic [4:0] SEG7_CODE_DASH  = 5'h10;
  localparam logic [4:0] SEG7_CODE_BLANK = 5'h11;

  // Active-low cathode patterns: [7] dp, [6:0] g..a.
  localparam logic [7:0] SEG7_PAT_BLANK = 8'hFF;
  localparam logic [7:0] SEG7_PAT_DASH  = 8'hBF;

  // All anodes disabled (active-low).
  localparam logic [3:0] SEG7_AN_OFF = 4'b1111;

  // Default timing for a 50 MHz clock: 1 kHz per digit, 500-cycle dead
  // window, 0.25 s blink half-period.
  localparam int unsigned SEG7_SCAN_DIV    = 32'd50000;
  localparam int unsigned SEG7_DEAD_CYCLES = 32'd500;
  localparam int unsigned SEG7_BLINK_DIV   = 32'd12500000;

  // Per-slot scan state: anodes off first, then the digit is shown.
  typedef enum logic {
    SCAN_DEAD = 1'b0,
    SCAN_LIT  = 1'b1
  } scan_state_e;

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational map from a 5-bit digit code to an active-low
// segment pattern, plus a flag marking codes that light nothing.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [4:0] code,
  output logic [7:0] pat,
  output logic       blank
);

  // Hex digits for bit4 = 0; dash or blank for the bit4 = 1 codes.
  always_comb begin
    pat   = SEG7_PAT_BLANK;
    blank = 1'b0;
    if (code[4] == 1'b0) begin
      case (code[3:0])
        4'h0:    pat = 8'hC0;
        4'h1:    pat = 8'hF9;
        4'h2:    pat = 8'hA4;
        4'h3:    pat = 8'hB0;
        4'h4:    pat = 8'h99;
        4'h5:    pat = 8'h92;
        4'h6:    pat = 8'h82;
        4'h7:    pat = 8'hF8;
        4'h8:    pat = 8'h80;
        4'h9:    pat = 8'h90;
        4'hA:    pat = 8'h88;
        4'hB:    pat = 8'h83;
        4'hC:    pat = 8'hC6;
        4'hD:    pat = 8'hA1;
        4'hE:    pat = 8'h86;
        4'hF:    pat = 8'h8E;
        default: pat = SEG7_PAT_BLANK;
      endcase
    end else if (code == SEG7_CODE_DASH) begin
      pat = SEG7_PAT_DASH;
    end else begin
      pat   = SEG7_PAT_BLANK;
      blank = 1'b1;
    end
  end

endmodule

// File: rtl/seg7_scanner.sv
// seg7_scanner: scans four digits one slot at a time, blanks the anodes for a
// dead window at the start of each slot, samples the digit code and blink
// state once per slot, and drives registered AN/SEG pins.
module seg7_scanner
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_DIV    = SEG7_SCAN_DIV,
  parameter int unsigned DEAD_CYCLES = SEG7_DEAD_CYCLES,
  parameter int unsigned BLINK_DIV   = SEG7_BLINK_DIV
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [19:0] SEG7DATA,
  input  logic [3:0]  SEG7BLINK,
  output logic [3:0]  AN,
  output logic [7:0]  SEG
);

  localparam int unsigned CNT_W = (SCAN_DIV > 32'd1) ? $clog2(SCAN_DIV) : 32'd1;
  localparam int unsigned BLK_W = (BLINK_DIV > 32'd1) ? $clog2(BLINK_DIV) : 32'd1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SCAN_DIV - 32'd1);
  localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(DEAD_CYCLES - 32'd1);
  localparam logic [BLK_W-1:0] BLK_LAST   = BLK_W'(BLINK_DIV - 32'd1);

  logic [CNT_W-1:0] cnt_r;
  logic [1:0]       idx_r;
  logic [BLK_W-1:0] blk_cnt_r;
  logic             phase_r;
  scan_state_e      state_r;
  logic [4:0]       lat_code_r;
  logic             lat_blink_r;
  logic             lat_phase_r;
  logic [3:0]       an_r;
  logic [7:0]       seg_r;

  logic             sample_s;
  logic             wrap_s;
  logic [4:0]       live_code_s;
  logic             live_blink_s;
  logic [4:0]       dec_code_s;
  logic             use_blink_s;
  logic             use_phase_s;
  logic [7:0]       dec_pat_s;
  logic             dec_blank_s;
  logic [3:0]       an_lit_s;
  logic [7:0]       seg_lit_s;

  assign sample_s = (cnt_r == CNT_SAMPLE);
  assign wrap_s   = (cnt_r == CNT_LAST);

  // Select the current digit's code and blink bit, and feed the decoder with
  // the live slice on the sample edge or the latched code while lit.
  always_comb begin
    live_code_s  = SEG7DATA[4:0];
    live_blink_s = SEG7BLINK[0];
    case (idx_r)
      2'd0:    begin live_code_s = SEG7DATA[4:0];   live_blink_s = SEG7BLINK[0]; end
      2'd1:    begin live_code_s = SEG7DATA[9:5];   live_blink_s = SEG7BLINK[1]; end
      2'd2:    begin live_code_s = SEG7DATA[14:10]; live_blink_s = SEG7BLINK[2]; end
      2'd3:    begin live_code_s = SEG7DATA[19:15]; live_blink_s = SEG7BLINK[3]; end
      default: begin live_code_s = SEG7DATA[4:0];   live_blink_s = SEG7BLINK[0]; end
    endcase
    if (sample_s) begin
      dec_code_s  = live_code_s;
      use_blink_s = live_blink_s;
      use_phase_s = phase_r;
    end else begin
      dec_code_s  = lat_code_r;
      use_blink_s = lat_blink_r;
      use_phase_s = lat_phase_r;
    end
  end

  seg7_decode u_decode (
    .code  (dec_code_s),
    .pat   (dec_pat_s),
    .blank (dec_blank_s)
  );

  // Lit-window output value: dark for blank codes or the blink-off phase.
  always_comb begin
    an_lit_s  = SEG7_AN_OFF;
    seg_lit_s = SEG7_PAT_BLANK;
    if (dec_blank_s || (use_blink_s && use_phase_s)) begin
      an_lit_s  = SEG7_AN_OFF;
      seg_lit_s = SEG7_PAT_BLANK;
    end else begin
      an_lit_s  = ~(4'b0001 << idx_r);
      seg_lit_s = dec_pat_s;
    end
  end

  // Slot counter and digit index; the index advances when the slot wraps.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_r <= {CNT_W{1'b0}};
      idx_r <= 2'd0;
    end else if (wrap_s) begin
      cnt_r <= {CNT_W{1'b0}};
      idx_r <= idx_r + 2'd1;
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  // Free-running blink counter; phase flips on every wrap.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      blk_cnt_r <= {BLK_W{1'b0}};
      phase_r   <= 1'b0;
    end else if (blk_cnt_r == BLK_LAST) begin
      blk_cnt_r <= {BLK_W{1'b0}};
      phase_r   <= ~phase_r;
    end else begin
      blk_cnt_r <= blk_cnt_r + BLK_W'(1);
    end
  end

  // DEAD/LIT slot FSM with sample latches and registered pin drivers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r     <= SCAN_DEAD;
      lat_code_r  <= SEG7_CODE_BLANK;
      lat_blink_r <= 1'b0;
      lat_phase_r <= 1'b0;
      an_r        <= SEG7_AN_OFF;
      seg_r       <= SEG7_PAT_BLANK;
    end else begin
      case (state_r)
        SCAN_DEAD: begin
          if (sample_s) begin
            state_r     <= SCAN_LIT;
            lat_code_r  <= live_code_s;
            lat_blink_r <= live_blink_s;
            lat_phase_r <= phase_r;
            an_r        <= an_lit_s;
            seg_r       <= seg_lit_s;
          end else begin
            an_r  <= SEG7_AN_OFF;
            seg_r <= SEG7_PAT_BLANK;
          end
        end
        SCAN_LIT: begin
          if (wrap_s) begin
            state_r <= SCAN_DEAD;
            an_r    <= SEG7_AN_OFF;
            seg_r   <= SEG7_PAT_BLANK;
          end else begin
            an_r  <= an_lit_s;
            seg_r <= seg_lit_s;
          end
        end
        default: begin
          state_r <= SCAN_DEAD;
          an_r    <= SEG7_AN_OFF;
          seg_r   <= SEG7_PAT_BLANK;
        end
      endcase
    end
  end

  assign AN  = an_r;
  assign SEG = seg_r;

endmodule

// File: tb/tb_seg7_scanner.sv
// tb_seg7_scanner: directed scenarios plus random input churn, checked every
// cycle against a model that derives slot, digit and blink phase from the
// number of clock edges since reset.
module tb_seg7_scanner;

  localparam int SD = 8;
  localparam int DC = 2;
  localparam int BD = 64;

  logic        CLK   = 1'b0;
  logic        RST_N = 1'b1;
  logic [19:0] SEG7DATA  = 20'h0;
  logic [3:0]  SEG7BLINK = 4'h0;
  logic [3:0]  AN;
  logic [7:0]  SEG;

  int tests = 0;
  int fails = 0;
  int k     = 0;

  logic [4:0] snap_code  = 5'h11;
  logic       snap_blink = 1'b0;
  logic       snap_phase = 1'b0;
  logic [3:0] exp_an     = 4'hF;
  logic [7:0] exp_seg    = 8'hFF;

  logic [7:0] hex_pat [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  always #5 CLK = ~CLK;

  seg7_scanner #(.SCAN_DIV(SD), .DEAD_CYCLES(DC), .BLINK_DIV(BD)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .SEG7DATA  (SEG7DATA),
    .SEG7BLINK (SEG7BLINK),
    .AN        (AN),
    .SEG       (SEG)
  );

  function automatic logic [7:0] pat_of(input logic [4:0] c);
    if (c < 5'd16) return hex_pat[c[3:0]];
    else if (c == 5'h10) return 8'hBF;
    else return 8'hFF;
  endfunction

  task automatic check(input string tag, input logic [3:0] an_e, input logic [7:0] seg_e);
    tests++;
    assert (AN === an_e) else begin
      fails++;
      $error("FAIL %s.an k=%0d got %b expected %b", tag, k, AN, an_e);
    end
    tests++;
    assert (SEG === seg_e) else begin
      fails++;
      $error("FAIL %s.seg k=%0d got %h expected %h", tag, k, SEG, seg_e);
    end
    tests++;
    assert (($countones(~AN) <= 1) === 1'b1) else begin
      fails++;
      $error("FAIL %s.onehot k=%0d got AN %b expected at most one low bit", tag, k, AN);
    end
  endtask

  // One clock: update the reference on the rising edge, compare on the falling edge.
  task automatic step(input string tag);
    int pos;
    int idx;
    @(posedge CLK);
    if (RST_N) begin
      k++;
      pos = k % SD;
      idx = (k / SD) % 4;
      if (pos == DC) begin
        snap_code  = SEG7DATA[idx*5 +: 5];
        snap_blink = SEG7BLINK[idx];
        snap_phase = (((k - 1) / BD) % 2) == 1;
      end
      if (pos < DC || pat_of(snap_code) == 8'hFF || (snap_blink && snap_phase)) begin
        exp_an  = 4'hF;
        exp_seg = 8'hFF;
      end else begin
        exp_an  = ~(4'b0001 << idx);
        exp_seg = pat_of(snap_code);
      end
    end else begin
      exp_an  = 4'hF;
      exp_seg = 8'hFF;
    end
    @(negedge CLK);
    check(tag, exp_an, exp_seg);
  endtask

  task automatic release_reset();
    RST_N      = 1'b1;
    k          = 0;
    snap_code  = 5'h11;
    snap_blink = 1'b0;
    snap_phase = 1'b0;
  endtask

  task automatic run_to(input int phase_mod, input string tag);
    for (int i = 0; i < 64 && (k % 32) != phase_mod; i++) step(tag);
    tests++;
    assert ((k % 32) === phase_mod) else begin
      fails++;
      $error("FAIL %s.reach got k%%32=%0d expected %0d", tag, k % 32, phase_mod);
    end
  endtask

  initial begin
    // Reset state, asynchronous, before any clock edge
    #1 RST_N = 1'b0;
    #1 check("reset", 4'b1111, 8'hFF);
    @(negedge CLK);
    release_reset();

    // First slot with all-zero codes
    for (int i = 0; i < 8; i++) step("first");

    // Scan order: digit3 blank, digit2 dash, digit1 F, digit0 8
    SEG7DATA = {5'h11, 5'h10, 5'h0F, 5'h08};
    for (int i = 0; i < 64; i++) step("scan");

    // Sampling: change digit 0 mid-slot, the old value must hold
    SEG7DATA[4:0] = 5'h01;
    run_to(4, "samp");
    check("samp_hold", 4'b1110, 8'hF9);
    SEG7DATA[4:0] = 5'h02;
    for (int i = 0; i < 4; i++) step("samp");
    run_to(4, "samp2");
    check("samp_next", 4'b1110, 8'hA4);

    // Asynchronous reset mid-slot of digit 2
    run_to(21, "arst");
    check("arst_pre", 4'b1011, 8'hBF);
    #1 RST_N = 1'b0;
    #1 check("arst_dark", 4'b1111, 8'hFF);
    step("arst_hold");
    step("arst_hold");
    release_reset();
    SEG7BLINK = 4'b0001;
    SEG7DATA  = {15'($urandom), 5'h07};
    for (int i = 0; i < 2; i++) step("arst_first");
    check("arst_dig0", 4'b1110, 8'hF8);

    // Blink: digit 0 lit during phase 0, dark during phase 1
    for (int i = 0; i < 158; i++) step("blink");

    // Random churn on codes and blink mask
    for (int i = 0; i < 400; i++) begin
      if (($urandom % 4) == 0) SEG7DATA = 20'($urandom);
      if (($urandom % 8) == 0) SEG7BLINK = 4'($urandom);
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
